cla_pipe_adder: RTL and testbench



---
 rtl/cla_pipe_pkg.sv | 22 ++
 rtl/cla_group4.sv | 33 +++
 rtl/cla_pipe_adder.sv | 119 +++++++++++
 tb/tb_cla_pipe_adder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pipe_pkg.sv
// cla_pipe_pkg: shared constants, types and helpers for the pipelined CLA adder.
//   CLA_GROUP_W  - width of one lookahead group (4 bits)
//   cla_stages() - pipeline depth for a given operand width and groups per stage
//   stage_ctl_t  - width-independent control half of a stage register
//                  (valid bit and carry handed to the next stage)
package cla_pipe_pkg;

    localparam int unsigned CLA_GROUP_W = 4;

    function automatic int unsigned cla_stages(input int unsigned width,
                                               input int unsigned groups_per_stage);
        return width / (CLA_GROUP_W * groups_per_stage);
    endfunction

    // The data half (partial sum, remaining operands) depends on WIDTH, so the
    // top module wraps this control struct in its own parameterised stage type.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group.
//   a, b : operand nibbles
//   cin  : carry into the group
//   sum  : 4-bit group sum
//   gg   : group generate (group produces a carry on its own)
//   gp   : group propagate (group passes cin straight through)
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       gg,
    output logic       gp
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every internal carry is a flat sum of products from cin; no bit ripple.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
    assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp  = &p;

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder with valid/ready handshake.
// Each stage sums GROUPS_PER_STAGE 4-bit lookahead groups and registers the
// partial sum, its carry out and the operands still to be summed.
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake; in_ready = !out_valid || out_ready
//   a, b, ci             : operands and carry in
//   out_valid / out_ready: output handshake
//   s, co, ov            : sum, carry out of MSB, signed overflow
// Optional: `define CLA_PIPE_SUB_EN adds input `sub` (1 = compute a - b).
module cla_pipe_adder
    import cla_pipe_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int unsigned SLICE_W = CLA_GROUP_W * GROUPS_PER_STAGE;
    localparam int unsigned STAGES  = cla_stages(WIDTH, GROUPS_PER_STAGE);

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_reg_t;

    stage_reg_t       stage_in [STAGES];
    stage_reg_t       stage_d  [STAGES];
    stage_reg_t       stage_q  [STAGES];
    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;

`ifdef CLA_PIPE_SUB_EN
    assign b_eff  = b ^ {WIDTH{sub}};
    assign ci_eff = ci ^ sub;
`else
    assign b_eff  = b;
    assign ci_eff = ci;
`endif

    assign out_valid = stage_q[STAGES-1].ctl.valid;
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign s         = stage_q[STAGES-1].sum;
    assign co        = stage_q[STAGES-1].ctl.carry;
    // The carry into the MSB is recovered from the stored MSB operands and
    // sum bit (s = a ^ b ^ c), so no extra register is needed for it.
    assign ov        = co ^ (stage_q[STAGES-1].sum[WIDTH-1] ^
                             stage_q[STAGES-1].a[WIDTH-1]   ^
                             stage_q[STAGES-1].b[WIDTH-1]);

    assign stage_in[0] = '{ctl: '{valid: in_valid, carry: ci_eff},
                           sum: '0, a: a, b: b_eff};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GROUPS_PER_STAGE:0]   carry;
        logic [GROUPS_PER_STAGE-1:0] grp_g;
        logic [GROUPS_PER_STAGE-1:0] grp_p;
        logic [SLICE_W-1:0]          slice_sum;
        stage_reg_t                  nxt;

        if (k > 0) begin : g_link
            assign stage_in[k] = stage_q[k-1];
        end

        assign carry[0] = stage_in[k].ctl.carry;

        for (genvar g = 0; g < GROUPS_PER_STAGE; g++) begin : g_group
            cla_group4 u_group (
                .a   (stage_in[k].a[k*SLICE_W + g*CLA_GROUP_W +: CLA_GROUP_W]),
                .b   (stage_in[k].b[k*SLICE_W + g*CLA_GROUP_W +: CLA_GROUP_W]),
                .cin (carry[g]),
                .sum (slice_sum[g*CLA_GROUP_W +: CLA_GROUP_W]),
                .gg  (grp_g[g]),
                .gp  (grp_p[g])
            );
            assign carry[g+1] = grp_g[g] | (grp_p[g] & carry[g]);
        end

        always_comb begin
            nxt                          = stage_in[k];
            nxt.ctl.carry                = carry[GROUPS_PER_STAGE];
            nxt.sum[k*SLICE_W +: SLICE_W] = slice_sum;
        end

        assign stage_d[k] = nxt;
    end

    // Global stall: every stage holds together whenever the output is blocked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: self-checking bench for cla_pipe_adder (WIDTH=32,
// GROUPS_PER_STAGE=2, four stages). The reference is plain 33-bit arithmetic
// held in a slot-per-cycle latency model with global stall.
module tb_cla_pipe_adder;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned GPS    = 2;
    localparam int unsigned STAGES = 4;

    typedef struct {
        bit             v;
        bit [WIDTH-1:0] s;
        bit             co;
        bit             ov;
    } exp_t;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             ci        = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    bit               sub_drv   = 1'b0;

    exp_t slot [STAGES];
    int   checks   = 0;
    int   failures = 0;

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUPS_PER_STAGE(GPS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef CLA_PIPE_SUB_EN
        .sub       (sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ov        (ov)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_result(input bit [WIDTH-1:0] x, input bit [WIDTH-1:0] y,
                                        input bit c, input bit sb);
        bit [WIDTH:0]   total;
        bit [WIDTH-1:0] yy;
        exp_t           r;
        yy    = sb ? ~y : y;
        total = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, c ^ sb};
        r.v   = 1'b1;
        r.s   = total[WIDTH-1:0];
        r.co  = total[WIDTH];
        r.ov  = (x[WIDTH-1] == yy[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < STAGES; i++) slot[i] = '{v: 1'b0, s: '0, co: 1'b0, ov: 1'b0};
    endtask

    task automatic drive(input bit v, input bit [WIDTH-1:0] x, input bit [WIDTH-1:0] y,
                         input bit c, input bit rdy);
        in_valid  = v;
        a         = x;
        b         = y;
        ci        = c;
        out_ready = rdy;
        #1;
    endtask

    // Advance the model exactly as the handshake rules dictate, then clock.
    task automatic tick();
        bit   adv;
        exp_t nw;
        adv = !slot[STAGES-1].v || out_ready;
        if (adv) begin
            nw   = ref_result(a, b, ci, sub_drv);
            nw.v = in_valid;
            for (int i = STAGES - 1; i > 0; i--) slot[i] = slot[i-1];
            slot[0] = nw;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_model();
        drive(0, '0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (s !== '0) begin failures++; $display("FAIL reset_s: got %h expected 0", s); end
        checks++; if (co !== 1'b0 || ov !== 1'b0) begin failures++; $display("FAIL reset_co_ov: got %b%b expected 00", co, ov); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_op();
        drive(1, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1);
        tick();
        for (int i = 2; i <= 4; i++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_latency_%0d: got %b expected 0", i, out_valid); end
            drive(0, '0, '0, 0, 1);
            tick();
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (s !== 32'h0 || co !== 1'b1 || ov !== 1'b0) begin failures++; $display("FAIL single_result: got s=%h co=%b ov=%b expected s=0 co=1 ov=0", s, co, ov); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        bit [WIDTH-1:0] ta [3] = '{32'h7FFF_FFFF, 32'hAAAA_AAAA, 32'hFFFF_FFFF};
        bit [WIDTH-1:0] tb [3] = '{32'h0000_0001, 32'hEEEE_EEEE, 32'h0000_0000};
        bit             tc [3] = '{1'b0, 1'b1, 1'b0};
        bit [WIDTH-1:0] es [3] = '{32'h8000_0000, 32'h9999_9999, 32'hFFFF_FFFF};
        bit             eco[3] = '{1'b0, 1'b1, 1'b0};
        bit             eov[3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1, ta[i], tb[i], tc[i], 1);
            tick();
        end
        drive(0, '0, '0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_early: got %b expected 0", out_valid); end
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || s !== es[j] || co !== eco[j] || ov !== eov[j]) begin
                failures++;
                $display("FAIL b2b_result_%0d: got v=%b s=%h co=%b ov=%b expected v=1 s=%h co=%b ov=%b",
                         j, out_valid, s, co, ov, es[j], eco[j], eov[j]);
            end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_carry_boundary();
        drive(1, 32'h0000_00FF, 32'h0000_0001, 0, 1);
        tick();
        drive(0, '0, '0, 0, 1);
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b1 || s !== 32'h0000_0100 || co !== 1'b0 || ov !== 1'b0) begin
            failures++;
            $display("FAIL carry_boundary: got v=%b s=%h co=%b ov=%b expected v=1 s=00000100 co=0 ov=0", out_valid, s, co, ov);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit [WIDTH-1:0] pa [3] = '{32'h1234_5678, 32'hFFFF_0000, 32'h8000_0000};
        bit [WIDTH-1:0] pb [3] = '{32'h1111_1111, 32'h0001_FFFF, 32'h8000_0000};
        exp_t           want [3];
        int             got = 0;
        bit             held_ok = 0;
        bit [WIDTH-1:0] held = '0;
        bit             rdy;
        for (int i = 0; i < 3; i++) want[i] = ref_result(pa[i], pb[i], 1'b0, 1'b0);
        for (int cyc = 0; cyc < 12; cyc++) begin
            rdy = !(cyc >= 2 && cyc <= 6);
            if (cyc < 3) drive(1, pa[cyc], pb[cyc], 0, rdy);
            else         drive(0, '0, '0, 0, rdy);
            checks++;
            if (in_ready !== (!slot[STAGES-1].v || rdy)) begin
                failures++; $display("FAIL bp_in_ready_%0d: got %b expected %b", cyc, in_ready, !slot[STAGES-1].v || rdy);
            end
            if (cyc == 4) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_drop: got %b expected 0", in_ready); end
            end
            if (out_valid && !rdy) begin
                if (held_ok) begin
                    checks++; if (s !== held) begin failures++; $display("FAIL bp_stall_stable_%0d: got %h expected %h", cyc, s, held); end
                end
                held = s;
                held_ok = 1;
            end
            if (out_valid && rdy) begin
                checks++;
                if (got >= 3) begin
                    failures++; $display("FAIL bp_duplicate: got extra result s=%h expected none", s);
                end else if (s !== want[got].s || co !== want[got].co || ov !== want[got].ov) begin
                    failures++;
                    $display("FAIL bp_order_%0d: got s=%h co=%b ov=%b expected s=%h co=%b ov=%b",
                             got, s, co, ov, want[got].s, want[got].co, want[got].ov);
                end
                got++;
            end
            tick();
        end
        checks++; if (got != 3) begin failures++; $display("FAIL bp_count: got %0d expected 3", got); end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h0101_0101 * (i + 1), 32'h0F0F_0F0F, 1, 1);
            tick();
        end
        drive(0, '0, '0, 0, 1);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
        reset_n = 1'b0;
        #1;
        clear_model();
        checks++; if (out_valid !== 1'b0 || s !== '0) begin failures++; $display("FAIL rst_async: got v=%b s=%h expected v=0 s=0", out_valid, s); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_ghost_%0d: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_random();
        bit [WIDTH-1:0] x, y;
        for (int cyc = 0; cyc < 400; cyc++) begin
            case ($urandom_range(0, 3))
                0:       x = '1;
                1:       x = '0;
                default: x = $urandom;
            endcase
            y = ($urandom_range(0, 4) == 0) ? ~x : $urandom;
`ifdef CLA_PIPE_SUB_EN
            sub_drv = bit'($urandom_range(0, 1));
`endif
            drive($urandom_range(0, 3) != 0, x, y, bit'($urandom_range(0, 1)),
                  (cyc >= 390) || ($urandom_range(0, 3) != 0));
            checks++;
            if (in_ready !== (!slot[STAGES-1].v || out_ready)) begin
                failures++; $display("FAIL rnd_in_ready_%0d: got %b expected %b", cyc, in_ready, !slot[STAGES-1].v || out_ready);
            end
            tick();
            checks++;
            if (out_valid !== slot[STAGES-1].v) begin
                failures++; $display("FAIL rnd_valid_%0d: got %b expected %b", cyc, out_valid, slot[STAGES-1].v);
            end else if (slot[STAGES-1].v &&
                         (s !== slot[STAGES-1].s || co !== slot[STAGES-1].co || ov !== slot[STAGES-1].ov)) begin
                failures++;
                $display("FAIL rnd_result_%0d: got s=%h co=%b ov=%b expected s=%h co=%b ov=%b",
                         cyc, s, co, ov, slot[STAGES-1].s, slot[STAGES-1].co, slot[STAGES-1].ov);
            end
        end
        sub_drv = 1'b0;
        drive(0, '0, '0, 0, 1);
        repeat (STAGES + 1) tick();
    endtask

`ifdef CLA_PIPE_SUB_EN
    task automatic test_sub();
        sub_drv = 1'b1;
        drive(1, 32'd5, 32'd7, 0, 1);
        tick();
        sub_drv = 1'b0;
        drive(0, '0, '0, 0, 1);
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b1 || s !== 32'hFFFF_FFFE || co !== 1'b0 || ov !== 1'b0) begin
            failures++;
            $display("FAIL sub_result: got v=%b s=%h co=%b ov=%b expected v=1 s=fffffffe co=0 ov=0", out_valid, s, co, ov);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_carry_boundary();
        test_backpressure();
        test_reset_midflight();
`ifdef CLA_PIPE_SUB_EN
        test_sub();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
